// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request bus between fetch_unit and imem
//
// Purpose: groups the instruction-memory handshake so that it can be passed
//          around as a single port.
// Signals:
//   imem_req    fetch -> mem  request valid
//   imem_addr   fetch -> mem  request address; held while req=1 and ready=0
//   imem_ready  mem -> fetch  imem_data is valid this cycle (may be zero-wait)
//   imem_data   mem -> fetch  returned instruction
// Modports: master = fetch_unit side, slave = memory side.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ready, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_data);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, imem request, IF/ID load
//
// Purpose: owns the program counter, keeps at most one instruction-memory
//          request outstanding, and loads the IF/ID register. Handles
//          downstream stall, branch/jump redirect and HALT.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   stall        IF/ID must not load this cycle
//   redirect     taken branch/jump; pc <= redirect_pc (highest priority)
//   redirect_pc  redirect target
//   imem         fetch_unit_if.master (imem_req/addr out, imem_ready/data in)
//   if_we        IF/ID load enable
//   if_instr     IF/ID instruction d input (valid when if_we=1)
//   if_pc_plus2  address of accepted instruction + 2 (valid when if_we=1)
//   fetch_pc     current pc
//   halted       high while in HALTED
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [15:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic               if_we,
  output logic [15:0]        if_instr,
  output logic [15:0]        if_pc_plus2,
  output logic [15:0]        fetch_pc,
  output logic               halted
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP, HALTED} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] drop_addr, drop_addr_n;
  logic [15:0] hold_instr, hold_instr_n;
  logic        req, we;
  logic [15:0] pc_plus2;

  assign pc_plus2 = pc + 16'd2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drop_addr  <= 16'h0000;
      hold_instr <= 16'h0000;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drop_addr  <= drop_addr_n;
      hold_instr <= hold_instr_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    drop_addr_n  = drop_addr;
    hold_instr_n = hold_instr;
    req          = 1'b0;
    we           = 1'b0;
    imem.imem_addr = pc;
    if_instr     = imem.imem_data;
    halted       = 1'b0;
    case (state)
      FETCH: begin
        req = 1'b1;
        if (redirect) begin
          pc_n = redirect_pc;
          // An unanswered request is still owned by memory; remember its
          // address so it can be held stable until the orphan returns.
          if (!imem.imem_ready) begin
            drop_addr_n = pc;
            state_n     = DROP;
          end
        end else if (imem.imem_ready) begin
          if (stall) begin
            hold_instr_n = imem.imem_data;
            state_n      = HOLD;
          end else begin
            we = 1'b1;
            if (imem.imem_data[15:11] == HALT_OPCODE) state_n = HALTED;
            else                                      pc_n    = pc_plus2;
          end
        end
      end
      HOLD: begin
        if_instr = hold_instr;
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = FETCH;
        end else if (!stall) begin
          we = 1'b1;
          if (hold_instr[15:11] == HALT_OPCODE) state_n = HALTED;
          else begin
            pc_n    = pc_plus2;
            state_n = FETCH;
          end
        end
      end
      DROP: begin
        req            = 1'b1;
        imem.imem_addr = drop_addr;
        if (redirect) pc_n = redirect_pc;
        // The orphan's completion ends DROP regardless of a further redirect.
        if (imem.imem_ready) state_n = FETCH;
      end
      HALTED: begin
        halted = 1'b1;
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // Reset forces FETCH, which would otherwise request; gating with rst makes
  // imem_req and if_we drop asynchronously the moment reset asserts.
  assign imem.imem_req = req & rst;
  assign if_we         = we & rst;
  assign if_pc_plus2   = pc_plus2;
  assign fetch_pc      = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        if_we;
  logic [15:0] if_instr;
  logic [15:0] if_pc_plus2;
  logic [15:0] fetch_pc;
  logic        halted;
  int          total = 0;
  int          bad   = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .if_we       (if_we),
    .if_instr    (if_instr),
    .if_pc_plus2 (if_pc_plus2),
    .fetch_pc    (fetch_pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rd;
    logic [15:0] rpc;
    logic        rdy;
    logic [15:0] dat;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_we;
    logic [15:0] e_instr;
    logic [15:0] e_p2;
    logic [15:0] e_pc;
    logic        e_halt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic st, input logic rd, input logic [15:0] rpc,
                             input logic rdy, input logic [15:0] dat,
                             input logic er, input logic [15:0] ea, input logic ew,
                             input logic [15:0] ei, input logic [15:0] ep,
                             input logic [15:0] epc, input logic eh);
    vec_t r;
    r.st = st; r.rd = rd; r.rpc = rpc; r.rdy = rdy; r.dat = dat;
    r.e_req = er; r.e_addr = ea; r.e_we = ew; r.e_instr = ei;
    r.e_p2 = ep; r.e_pc = epc; r.e_halt = eh;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  initial begin
    //             st rd rpc       rdy dat        req addr      we instr      p2         pc         halt
    // zero-wait after reset: p2 = 2,4,6,8
    vq.push_back(v(O, O, 16'h0000, I, 16'h1000, I, 16'h0000, I, 16'h1000, 16'h0002, 16'h0000, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h1002, I, 16'h0002, I, 16'h1002, 16'h0004, 16'h0002, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h1004, I, 16'h0004, I, 16'h1004, 16'h0006, 16'h0004, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h1006, I, 16'h0006, I, 16'h1006, 16'h0008, 16'h0006, O));
    // redirect with data ready: data dropped, pc -> 4
    vq.push_back(v(O, I, 16'h0004, I, 16'h1008, I, 16'h0008, O, 16'h0000, 16'h0000, 16'h0008, O));
    // 3 wait cycles at pc=4, then single accept
    vq.push_back(v(O, O, 16'h0000, O, 16'hdead, I, 16'h0004, O, 16'h0000, 16'h0000, 16'h0004, O));
    vq.push_back(v(O, O, 16'h0000, O, 16'hdead, I, 16'h0004, O, 16'h0000, 16'h0000, 16'h0004, O));
    vq.push_back(v(O, O, 16'h0000, O, 16'hdead, I, 16'h0004, O, 16'h0000, 16'h0000, 16'h0004, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h1004, I, 16'h0004, I, 16'h1004, 16'h0006, 16'h0004, O));
    // redirect to 0x10, then stall for 3 cycles as data arrives
    vq.push_back(v(O, I, 16'h0010, I, 16'h1006, I, 16'h0006, O, 16'h0000, 16'h0000, 16'h0006, O));
    vq.push_back(v(I, O, 16'h0000, I, 16'h1010, I, 16'h0010, O, 16'h0000, 16'h0000, 16'h0010, O));
    vq.push_back(v(I, O, 16'h0000, I, 16'hbeef, O, 16'h0000, O, 16'h0000, 16'h0000, 16'h0010, O));
    vq.push_back(v(I, O, 16'h0000, I, 16'hbeef, O, 16'h0000, O, 16'h0000, 16'h0000, 16'h0010, O));
    vq.push_back(v(O, O, 16'h0000, O, 16'hbeef, O, 16'h0000, I, 16'h1010, 16'h0012, 16'h0010, O));
    // redirect to 0x20, then redirect to 0x100 while 0x20 is pending (2 waits)
    vq.push_back(v(O, I, 16'h0020, I, 16'h1012, I, 16'h0012, O, 16'h0000, 16'h0000, 16'h0012, O));
    vq.push_back(v(O, I, 16'h0100, O, 16'hdead, I, 16'h0020, O, 16'h0000, 16'h0000, 16'h0020, O));
    vq.push_back(v(O, O, 16'h0000, O, 16'hdead, I, 16'h0020, O, 16'h0000, 16'h0000, 16'h0100, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h1020, I, 16'h0020, O, 16'h0000, 16'h0000, 16'h0100, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h1100, I, 16'h0100, I, 16'h1100, 16'h0102, 16'h0100, O));
    // HALT fetched at 0x30, ignore memory while halted, redirect to 0x40
    vq.push_back(v(O, I, 16'h0030, I, 16'h1102, I, 16'h0102, O, 16'h0000, 16'h0000, 16'h0102, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h0000, I, 16'h0030, I, 16'h0000, 16'h0032, 16'h0030, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h1234, O, 16'h0000, O, 16'h0000, 16'h0000, 16'h0030, I));
    vq.push_back(v(O, I, 16'h0040, I, 16'h1234, O, 16'h0000, O, 16'h0000, 16'h0000, 16'h0030, I));
    vq.push_back(v(O, O, 16'h0000, I, 16'h1040, I, 16'h0040, I, 16'h1040, 16'h0042, 16'h0040, O));
    // redirect to 0xFFFE with request pending, orphan returns, wrap to 0
    vq.push_back(v(O, I, 16'hfffe, O, 16'hdead, I, 16'h0042, O, 16'h0000, 16'h0000, 16'h0042, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h1042, I, 16'h0042, O, 16'h0000, 16'h0000, 16'hfffe, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h0ffe, I, 16'hfffe, I, 16'h0ffe, 16'h0000, 16'hfffe, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h1000, I, 16'h0000, I, 16'h1000, 16'h0002, 16'h0000, O));
    // stall and redirect together: redirect wins, no HOLD
    vq.push_back(v(I, I, 16'h0050, I, 16'h1002, I, 16'h0002, O, 16'h0000, 16'h0000, 16'h0002, O));
    vq.push_back(v(O, O, 16'h0000, I, 16'h1050, I, 16'h0050, I, 16'h1050, 16'h0052, 16'h0050, O));

    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    bus.imem_ready = 1'b1; bus.imem_data = 16'h1000;
    #2;
    chk("rst.req",  16'(bus.imem_req), 16'h0000);
    chk("rst.we",   16'(if_we),        16'h0000);
    chk("rst.halt", 16'(halted),       16'h0000);
    chk("rst.pc",   fetch_pc,          16'h0000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      stall = vq[i].st; redirect = vq[i].rd; redirect_pc = vq[i].rpc;
      bus.imem_ready = vq[i].rdy; bus.imem_data = vq[i].dat;
      #2;
      chk($sformatf("v%0d.req", i),  16'(bus.imem_req), 16'(vq[i].e_req));
      chk($sformatf("v%0d.we", i),   16'(if_we),        16'(vq[i].e_we));
      chk($sformatf("v%0d.pc", i),   fetch_pc,          vq[i].e_pc);
      chk($sformatf("v%0d.halt", i), 16'(halted),       16'(vq[i].e_halt));
      if (vq[i].e_req) chk($sformatf("v%0d.addr", i), bus.imem_addr, vq[i].e_addr);
      if (vq[i].e_we) begin
        chk($sformatf("v%0d.instr", i), if_instr,    vq[i].e_instr);
        chk($sformatf("v%0d.p2", i),    if_pc_plus2, vq[i].e_p2);
      end
      @(negedge clk);
    end

    // reset pulsed mid-wait: request drops at once, late ready ignored
    stall = 1'b0; redirect = 1'b0; bus.imem_ready = 1'b0; bus.imem_data = 16'hdead;
    #2;
    chk("mid.req0",  16'(bus.imem_req), 16'h0001);
    chk("mid.addr0", bus.imem_addr,     16'h0052);
    #1 rst = 1'b0;
    #1 bus.imem_ready = 1'b1;
    #0.1;
    chk("mid.req1", 16'(bus.imem_req), 16'h0000);
    chk("mid.we1",  16'(if_we),        16'h0000);
    chk("mid.pc1",  fetch_pc,          16'h0000);
    @(negedge clk);
    chk("mid.pc2",  fetch_pc,          16'h0000);
    rst = 1'b1; bus.imem_data = 16'h1000;
    #2;
    chk("mid.req3",  16'(bus.imem_req), 16'h0001);
    chk("mid.addr3", bus.imem_addr,     16'h0000);
    chk("mid.we3",   16'(if_we),        16'h0001);
    chk("mid.p23",   if_pc_plus2,       16'h0002);
    @(negedge clk);
    chk("mid.pc4",   fetch_pc,          16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
